// File: rtl/ahb_arb_pkg.sv
// Shared types and HTRANS encodings for the two-master AHB-Lite arbiter.
// ARB_FIXED_PRIO_EN selects fixed M0 priority instead of round-robin.
package ahb_arb_pkg;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    DP_M0 = 2'd1,
    DP_M1 = 2'd2
  } owner_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } mst_t;

  function automatic logic ht_active(input logic [1:0] t);
    return (t != HT_IDLE) && (t != HT_BUSY);
  endfunction

endpackage

// File: rtl/ahb_arb_hold.sv
// Per-master address-phase holding stage with pend flag and HREADY.
// Shared by both ports of ahb_lite_arb2 (see ARB_FIXED_PRIO_EN there).
module ahb_arb_hold
  import ahb_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_haddr,
  input  logic [1:0]        i_htrans,
  input  logic              i_hwrite,
  input  logic [2:0]        i_hsize,
  input  logic              i_grant,
  input  logic              i_own_dp,
  input  logic              i_s_hreadyout,
  output logic              o_req,
  output logic              o_hready,
  output logic [ADDR_W-1:0] o_haddr,
  output logic              o_hwrite,
  output logic [2:0]        o_hsize
);

  logic              r_pend;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [2:0]        r_size;
  logic              w_live;

  assign o_hready = r_pend   ? 1'b0 :
                    i_own_dp ? i_s_hreadyout : 1'b1;
  assign w_live   = ht_active(i_htrans) & o_hready;
  assign o_req    = r_pend | w_live;

  assign o_haddr  = r_pend ? r_addr  : i_haddr;
  assign o_hwrite = r_pend ? r_write : i_hwrite;
  assign o_hsize  = r_pend ? r_size  : i_hsize;

  // an accepted-but-not-granted request must survive until granted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend  <= 1'b0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= 3'b000;
    end else if (i_grant) begin
      r_pend  <= 1'b0;
    end else if (w_live) begin
      r_pend  <= 1'b1;
      r_addr  <= i_haddr;
      r_write <= i_hwrite;
      r_size  <= i_hsize;
    end
  end

endmodule

// File: rtl/ahb_lite_arb2.sv
// Two-master AHB-Lite arbiter onto one slave, round-robin on ties.
// Define ARB_FIXED_PRIO_EN to make M0 win every tie.
module ahb_lite_arb2
  import ahb_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [ADDR_W-1:0] M0_HADDR,
  input  logic [1:0]        M0_HTRANS,
  input  logic              M0_HWRITE,
  input  logic [2:0]        M0_HSIZE,
  input  logic [DATA_W-1:0] M0_HWDATA,
  output logic              M0_HREADY,
  output logic [DATA_W-1:0] M0_HRDATA,
  input  logic [ADDR_W-1:0] M1_HADDR,
  input  logic [1:0]        M1_HTRANS,
  input  logic              M1_HWRITE,
  input  logic [2:0]        M1_HSIZE,
  input  logic [DATA_W-1:0] M1_HWDATA,
  output logic              M1_HREADY,
  output logic [DATA_W-1:0] M1_HRDATA,
  output logic              S_HSEL,
  output logic [ADDR_W-1:0] S_HADDR,
  output logic [1:0]        S_HTRANS,
  output logic              S_HWRITE,
  output logic [2:0]        S_HSIZE,
  output logic [DATA_W-1:0] S_HWDATA,
  output logic              S_HREADY,
  input  logic              S_HREADYOUT,
  input  logic [DATA_W-1:0] S_HRDATA
);

  owner_t            r_owner;
  owner_t            w_owner_nxt;
  logic              w_req0, w_req1;
  logic              w_gnt0, w_gnt1;
  logic              w_tie_m0;
  logic [ADDR_W-1:0] w_addr0, w_addr1;
  logic              w_write0, w_write1;
  logic [2:0]        w_size0, w_size1;

  ahb_arb_hold #(.ADDR_W(ADDR_W)) u_hold0 (
    .i_clk         (HCLK),
    .i_rst_n       (HRESETn),
    .i_haddr       (M0_HADDR),
    .i_htrans      (M0_HTRANS),
    .i_hwrite      (M0_HWRITE),
    .i_hsize       (M0_HSIZE),
    .i_grant       (w_gnt0),
    .i_own_dp      (r_owner == DP_M0),
    .i_s_hreadyout (S_HREADYOUT),
    .o_req         (w_req0),
    .o_hready      (M0_HREADY),
    .o_haddr       (w_addr0),
    .o_hwrite      (w_write0),
    .o_hsize       (w_size0)
  );

  ahb_arb_hold #(.ADDR_W(ADDR_W)) u_hold1 (
    .i_clk         (HCLK),
    .i_rst_n       (HRESETn),
    .i_haddr       (M1_HADDR),
    .i_htrans      (M1_HTRANS),
    .i_hwrite      (M1_HWRITE),
    .i_hsize       (M1_HSIZE),
    .i_grant       (w_gnt1),
    .i_own_dp      (r_owner == DP_M1),
    .i_s_hreadyout (S_HREADYOUT),
    .o_req         (w_req1),
    .o_hready      (M1_HREADY),
    .o_haddr       (w_addr1),
    .o_hwrite      (w_write1),
    .o_hsize       (w_size1)
  );

`ifdef ARB_FIXED_PRIO_EN
  assign w_tie_m0 = 1'b1;
`else
  mst_t r_last;

  assign w_tie_m0 = (r_last == M1);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_last <= M1;
    end else if (w_gnt0 | w_gnt1) begin
      r_last <= w_gnt1 ? M1 : M0;
    end
  end
`endif

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (S_HREADYOUT) begin
      unique case (1'b1)
        (w_req0 &  w_req1): begin
          w_gnt0 = w_tie_m0;
          w_gnt1 = ~w_tie_m0;
        end
        (w_req0 & ~w_req1): w_gnt0 = 1'b1;
        (~w_req0 & w_req1): w_gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_owner <= NONE;
    else          r_owner <= w_owner_nxt;
  end

  always_comb begin
    w_owner_nxt = r_owner;
    if (S_HREADYOUT) begin
      unique case (1'b1)
        w_gnt0:  w_owner_nxt = DP_M0;
        w_gnt1:  w_owner_nxt = DP_M1;
        default: w_owner_nxt = NONE;
      endcase
    end
  end

  // SEQ context is lost across interleaving, so every beat goes out NONSEQ
  assign S_HSEL    = w_gnt0 | w_gnt1;
  assign S_HTRANS  = S_HSEL ? HT_NONSEQ : HT_IDLE;
  assign S_HADDR   = w_gnt1 ? w_addr1  : w_addr0;
  assign S_HWRITE  = w_gnt1 ? w_write1 : w_write0;
  assign S_HSIZE   = w_gnt1 ? w_size1  : w_size0;
  assign S_HWDATA  = (r_owner == DP_M1) ? M1_HWDATA : M0_HWDATA;
  assign S_HREADY  = S_HREADYOUT;
  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;

endmodule

// File: tb/tb_ahb_lite_arb2.sv
// Scoreboard bench for ahb_lite_arb2: master BFMs, memory slave, monitor.
// Expected orders follow ARB_FIXED_PRIO_EN when it is defined.
module tb_ahb_lite_arb2;

  typedef struct packed {
    logic [1:0]  tr;
    logic        wr;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] d;
  } cmd_t;

  typedef struct packed {
    logic [31:0] a;
    logic        wr;
    logic [2:0]  sz;
  } exp_t;

  logic        HCLK, HRESETn;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic        M0_HREADY, M1_HREADY;
  logic [31:0] M0_HRDATA, M1_HRDATA;
  logic        S_HSEL, S_HWRITE, S_HREADY, S_HREADYOUT;
  logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
  logic [1:0]  S_HTRANS;
  logic [2:0]  S_HSIZE;

  logic [31:0] m_haddr [2];
  logic [1:0]  m_htrans[2];
  logic        m_hwrite[2];
  logic [2:0]  m_hsize [2];
  logic [31:0] m_hwdata[2];
  bit          busy[2];

  cmd_t cq0[$];
  cmd_t cq1[$];
  exp_t exp_q[$];

  int checks = 0, failures = 0;
  int lowcnt0 = 0, lowcnt1 = 0;
  int cyc = 0, acc_n = 0, acc_first = 0, acc_last = 0;

  // masters share HRESETn, so they drop to IDLE while it is low
  assign M0_HTRANS = HRESETn ? m_htrans[0] : 2'b00;
  assign M1_HTRANS = HRESETn ? m_htrans[1] : 2'b00;
  assign M0_HADDR  = m_haddr[0];
  assign M1_HADDR  = m_haddr[1];
  assign M0_HWRITE = m_hwrite[0];
  assign M1_HWRITE = m_hwrite[1];
  assign M0_HSIZE  = m_hsize[0];
  assign M1_HSIZE  = m_hsize[1];
  assign M0_HWDATA = m_hwdata[0];
  assign M1_HWDATA = m_hwdata[1];

  ahb_lite_arb2 dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
    .M0_HSIZE(M0_HSIZE), .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY),
    .M0_HRDATA(M0_HRDATA),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
    .M1_HSIZE(M1_HSIZE), .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY),
    .M1_HRDATA(M1_HRDATA),
    .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS),
    .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE), .S_HWDATA(S_HWDATA),
    .S_HREADY(S_HREADY), .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // memory slave: word i resets to C0DE0000+i; two wait states for 0x400
  logic [31:0] mem[512];
  logic        sdp_act, sdp_wr;
  logic [31:0] sdp_addr;
  logic [2:0]  sdp_sz;
  int          wcnt;
  int          ln;

  assign S_HREADYOUT = (wcnt == 0);
  assign S_HRDATA    = mem[sdp_addr[10:2]];

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'hC0DE0000 + i;
      sdp_act  <= 1'b0;
      sdp_wr   <= 1'b0;
      sdp_addr <= '0;
      sdp_sz   <= 3'b000;
      wcnt     <= 0;
    end else if (wcnt != 0) begin
      wcnt <= wcnt - 1;
    end else begin
      if (sdp_act && sdp_wr) begin
        ln = int'(sdp_addr[1:0]);
        case (sdp_sz)
          3'b000:  mem[sdp_addr[10:2]][ln*8 +: 8] <= S_HWDATA[ln*8 +: 8];
          3'b001:  mem[sdp_addr[10:2]][(ln/2)*16 +: 16] <= S_HWDATA[(ln/2)*16 +: 16];
          default: mem[sdp_addr[10:2]] <= S_HWDATA;
        endcase
      end
      sdp_act  <= S_HSEL & S_HTRANS[1];
      sdp_wr   <= S_HWRITE;
      sdp_addr <= S_HADDR;
      sdp_sz   <= S_HSIZE;
      if (S_HSEL && S_HTRANS[1] && S_HADDR == 32'h400) wcnt <= 2;
    end
  end

  // monitor: every slave address phase must match the next expected one
  always @(negedge HCLK) begin
    exp_t e;
    if (HRESETn) begin
      cyc++;
      if (!M0_HREADY) lowcnt0++;
      if (!M1_HREADY) lowcnt1++;
      if (!S_HREADY) begin
        checks++;
        if (S_HSEL !== 1'b0) begin
          failures++;
          $display("FAIL sel_while_stalled S_HSEL=%b required=0", S_HSEL);
        end
      end else if (S_HSEL) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_xfer addr=%h none expected", S_HADDR);
        end else begin
          e = exp_q.pop_front();
          if (S_HTRANS !== 2'b10 || S_HADDR !== e.a ||
              S_HWRITE !== e.wr || S_HSIZE !== e.sz) begin
            failures++;
            $display("FAIL slave_xfer got tr=%b a=%h w=%b sz=%b required tr=10 a=%h w=%b sz=%b",
                     S_HTRANS, S_HADDR, S_HWRITE, S_HSIZE, e.a, e.wr, e.sz);
          end
        end
        if (acc_n == 0) acc_first = cyc;
        acc_last = cyc;
        acc_n++;
      end
    end
  end

  task automatic bfm(input int m);
    cmd_t ap, dp;
    bit ap_v, dp_v;
    logic rdy;
    logic [31:0] rd;
    ap = '0; dp = '0; ap_v = 0; dp_v = 0;
    forever begin
      @(negedge HCLK);
      rdy = (m == 0) ? M0_HREADY : M1_HREADY;
      rd  = (m == 0) ? M0_HRDATA : M1_HRDATA;
      @(posedge HCLK);
      if (!HRESETn) begin
        ap_v = 0; dp_v = 0;
        if (m == 0) cq0.delete(); else cq1.delete();
      end else if (rdy) begin
        if (dp_v && !dp.wr) begin
          checks++;
          if (rd !== dp.d) begin
            failures++;
            $display("FAIL m%0d_rdata addr=%h got=%h required=%h", m, dp.a, rd, dp.d);
          end
        end
        dp   = ap;
        dp_v = ap_v && ap.tr[1];
        ap_v = 0;
        if (m == 0 && cq0.size() > 0) begin ap = cq0.pop_front(); ap_v = 1; end
        if (m == 1 && cq1.size() > 0) begin ap = cq1.pop_front(); ap_v = 1; end
      end
      busy[m] = ap_v | dp_v;
      #1;
      m_htrans[m] = ap_v ? ap.tr : 2'b00;
      m_haddr[m]  = ap.a;
      m_hwrite[m] = ap.wr;
      m_hsize[m]  = ap.sz;
      if (dp_v && dp.wr) m_hwdata[m] = dp.d;
    end
  endtask

  initial bfm(0);
  initial bfm(1);

  function automatic cmd_t mk(input logic [1:0] tr, input logic wr,
                              input logic [31:0] a, input logic [2:0] sz,
                              input logic [31:0] d);
    cmd_t c;
    c.tr = tr; c.wr = wr; c.a = a; c.sz = sz; c.d = d;
    return c;
  endfunction

  function automatic exp_t ex(input logic [31:0] a, input logic wr,
                              input logic [2:0] sz);
    exp_t e;
    e.a = a; e.wr = wr; e.sz = sz;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", nm, act, req);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((cq0.size() > 0 || cq1.size() > 0 || busy[0] || busy[1] ||
            exp_q.size() > 0) && n < 60) begin
      @(negedge HCLK);
      n++;
    end
    checks++;
    if (n >= 60) begin
      failures++;
      $display("FAIL %s_timeout got=%0d cycles required<60", nm, n);
    end
    repeat (2) @(negedge HCLK);
  endtask

  localparam logic [1:0] ID = 2'b00, NS = 2'b10, SQ = 2'b11;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_haddr[i] = '0; m_htrans[i] = ID; m_hwrite[i] = 0;
      m_hsize[i] = 3'b010; m_hwdata[i] = '0; busy[i] = 0;
    end
    HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    chk("rst_m0_hready", 32'(M0_HREADY), 1);
    chk("rst_m1_hready", 32'(M1_HREADY), 1);
    chk("rst_s_hsel",    32'(S_HSEL), 0);
    chk("rst_s_htrans",  32'(S_HTRANS), 0);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);

    // first tie after reset: M0 first, M1 stalled one cycle
    lowcnt0 = 0; lowcnt1 = 0;
    exp_q.push_back(ex(32'h200, 1, 3'b010));
    exp_q.push_back(ex(32'h300, 1, 3'b010));
    cq0.push_back(mk(NS, 1, 32'h200, 3'b010, 32'hAAAA5555));
    cq1.push_back(mk(NS, 1, 32'h300, 3'b010, 32'h12345678));
    wait_idle("t2");
    chk("t2_m1_stall", lowcnt1, 1);
    chk("t2_m0_stall", lowcnt0, 0);

    // M0-only burst, SEQ forwarded as NONSEQ back to back
    lowcnt0 = 0; acc_n = 0;
    exp_q.push_back(ex(32'h100, 0, 3'b010));
    exp_q.push_back(ex(32'h104, 0, 3'b010));
    exp_q.push_back(ex(32'h108, 0, 3'b010));
    cq0.push_back(mk(NS, 0, 32'h100, 3'b010, 32'hC0DE0040));
    cq0.push_back(mk(SQ, 0, 32'h104, 3'b010, 32'hC0DE0041));
    cq0.push_back(mk(SQ, 0, 32'h108, 3'b010, 32'hC0DE0042));
    wait_idle("t1");
    chk("t1_span", acc_last - acc_first, 2);
    chk("t1_m0_stall", lowcnt0, 0);

    exp_q.push_back(ex(32'h200, 0, 3'b010));
    cq0.push_back(mk(NS, 0, 32'h200, 3'b010, 32'hAAAA5555));
    wait_idle("rb0");
    exp_q.push_back(ex(32'h300, 0, 3'b010));
    cq1.push_back(mk(NS, 0, 32'h300, 3'b010, 32'h12345678));
    wait_idle("rb1");

    // two consecutive ties
`ifdef ARB_FIXED_PRIO_EN
    exp_q.push_back(ex(32'h600, 0, 3'b010));
    exp_q.push_back(ex(32'h604, 0, 3'b010));
    exp_q.push_back(ex(32'h700, 0, 3'b010));
    exp_q.push_back(ex(32'h704, 0, 3'b010));
`else
    exp_q.push_back(ex(32'h600, 0, 3'b010));
    exp_q.push_back(ex(32'h700, 0, 3'b010));
    exp_q.push_back(ex(32'h604, 0, 3'b010));
    exp_q.push_back(ex(32'h704, 0, 3'b010));
`endif
    cq0.push_back(mk(NS, 0, 32'h600, 3'b010, 32'hC0DE0180));
    cq0.push_back(mk(NS, 0, 32'h604, 3'b010, 32'hC0DE0181));
    cq1.push_back(mk(NS, 0, 32'h700, 3'b010, 32'hC0DE01C0));
    cq1.push_back(mk(NS, 0, 32'h704, 3'b010, 32'hC0DE01C1));
    wait_idle("t3");

    // wait-state slave during M0 read, M1 arrives while stalled
    lowcnt0 = 0; lowcnt1 = 0;
    exp_q.push_back(ex(32'h400, 0, 3'b010));
    exp_q.push_back(ex(32'h480, 0, 3'b010));
    cq0.push_back(mk(NS, 0, 32'h400, 3'b010, 32'hC0DE0100));
    cq1.push_back(mk(ID, 0, 32'h0,   3'b010, 32'h0));
    cq1.push_back(mk(NS, 0, 32'h480, 3'b010, 32'hC0DE0120));
    wait_idle("t4");
    chk("t4_m0_stall", lowcnt0, 2);
    chk("t4_m1_stall", lowcnt1, 2);

    // byte write from M1 interleaved with an M0 SEQ read burst
`ifdef ARB_FIXED_PRIO_EN
    exp_q.push_back(ex(32'h510, 0, 3'b010));
    exp_q.push_back(ex(32'h514, 0, 3'b010));
    exp_q.push_back(ex(32'h518, 0, 3'b010));
    exp_q.push_back(ex(32'h501, 1, 3'b000));
`else
    exp_q.push_back(ex(32'h510, 0, 3'b010));
    exp_q.push_back(ex(32'h501, 1, 3'b000));
    exp_q.push_back(ex(32'h514, 0, 3'b010));
    exp_q.push_back(ex(32'h518, 0, 3'b010));
`endif
    cq0.push_back(mk(NS, 0, 32'h510, 3'b010, 32'hC0DE0144));
    cq0.push_back(mk(SQ, 0, 32'h514, 3'b010, 32'hC0DE0145));
    cq0.push_back(mk(SQ, 0, 32'h518, 3'b010, 32'hC0DE0146));
    cq1.push_back(mk(NS, 1, 32'h501, 3'b000, 32'h0000CD00));
    wait_idle("t5");
    exp_q.push_back(ex(32'h500, 0, 3'b010));
    cq0.push_back(mk(NS, 0, 32'h500, 3'b010, 32'hC0DECD40));
    wait_idle("t5_rb");

    // reset while M1 is pending behind a stalled M0 read
    exp_q.push_back(ex(32'h400, 0, 3'b010));
    cq0.push_back(mk(NS, 0, 32'h400, 3'b010, 32'hC0DE0100));
    cq1.push_back(mk(ID, 0, 32'h0,   3'b010, 32'h0));
    cq1.push_back(mk(NS, 0, 32'h480, 3'b010, 32'hC0DE0120));
    repeat (3) @(posedge HCLK);
    #2;
    chk("t6_m1_pending", 32'(M1_HREADY), 0);
    chk("t6_m0_waiting", 32'(M0_HREADY), 0);
    HRESETn = 1'b0;
    #1;
    chk("t6_m1_hready", 32'(M1_HREADY), 1);
    chk("t6_m0_hready", 32'(M0_HREADY), 1);
    chk("t6_s_htrans",  32'(S_HTRANS), 0);
    chk("t6_s_hsel",    32'(S_HSEL), 0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (4) @(negedge HCLK);
    wait_idle("t6");
    chk("t6_no_stray", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
